// File: rtl/sequence_generator.sv
// Serial pattern generator: sends the low len+1 bits of a captured pattern MSB-first,
// reps+1 times with optional idle gaps between passes, and pulses done at the end.
module sequence_generator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP        = 0,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH)-1:0] len,
    input  logic [3:0]               reps,
    output logic                     o,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam int unsigned PW = 1 << LW;
    localparam logic [3:0]  GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   pattern_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   bitIdx_q;
    logic [3:0]      passLeft_q;
    logic [3:0]      gapCnt_q;
    logic            o_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    // Padded to a power of two so any len value indexes a defined (zero) bit.
    logic [PW-1:0]   patternExt;
    assign patternExt = PW'(pattern);

    // bitIdx_q always names the pattern bit currently on o while in ST_SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pattern_q  <= '0;
            len_q      <= '0;
            bitIdx_q   <= '0;
            passLeft_q <= '0;
            gapCnt_q   <= '0;
            o_q        <= IDLE_LEVEL;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    o_q     <= IDLE_LEVEL;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        pattern_q  <= patternExt;
                        len_q      <= len;
                        passLeft_q <= reps;
                        bitIdx_q   <= len;
                        o_q        <= patternExt[len];
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bitIdx_q != '0) begin
                        bitIdx_q <= bitIdx_q - 1'b1;
                        o_q      <= pattern_q[bitIdx_q - 1'b1];
                    end else if (passLeft_q != 4'd0) begin
                        passLeft_q <= passLeft_q - 4'd1;
                        if (GAP > 0) begin
                            state_q  <= ST_GAP;
                            gapCnt_q <= GAP_LOAD;
                            o_q      <= IDLE_LEVEL;
                            valid_q  <= 1'b0;
                        end else begin
                            bitIdx_q <= len_q;
                            o_q      <= pattern_q[len_q];
                        end
                    end else begin
                        state_q <= ST_DONE;
                        o_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gapCnt_q == 4'd0) begin
                        state_q  <= ST_SHIFT;
                        bitIdx_q <= len_q;
                        o_q      <= pattern_q[len_q];
                        valid_q  <= 1'b1;
                    end else begin
                        gapCnt_q <= gapCnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    o_q     <= IDLE_LEVEL;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the maximum pattern length in bits (supported range 2..16).
REQ-002 SHALL provide parameter GAP, default 0, meaning the number of idle cycles inserted between repetitions (supported range 0..15).
REQ-003 SHALL provide parameter IDLE_LEVEL, default 1'b0, meaning the level driven on o whenever no pattern bit is being sent.
REQ-004 SHALL have clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-007 SHALL have pattern  input  WIDTH  the bits to send; captured when start is accepted.
REQ-008 SHALL have len  input  $clog2(WIDTH)  the pattern length minus 1; captured when start is accepted.
REQ-009 SHALL have reps  input  4  the number of extra repetitions; captured when start is accepted.
REQ-010 SHALL have o  output  1  the serial bit stream fed to the downstream sequence detector input i.
REQ-011 SHALL have valid  output  1  high in every cycle in which o carries a pattern bit.
REQ-012 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have done  output  1  a one-cycle pulse marking the end of a transmission.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-015 Accept: in IDLE with start=1 at edge N, SHALL capture pattern, len and reps, then enter SHIFT; the first bit SHALL appear on o with valid=1 in cycle N+1 (latency 1).
REQ-016 Bit order SHALL be MSB-first over the active field: pattern[len], pattern[len-1], ..., pattern[0], one bit per cycle; bits above len SHALL be ignored.
REQ-017 Pass length SHALL be len+1 cycles; the total number of passes SHALL be reps+1.
REQ-018 After the last bit of a pass with passes remaining: GAP>0 SHALL enter GAP for exactly GAP cycles (valid=0, o=IDLE_LEVEL) and then return to SHIFT at pattern[len]; GAP=0 SHALL start the next pass back-to-back in the following cycle.
REQ-019 After the last bit of the final pass, SHALL enter DONE for one cycle with done=1, valid=0 and o=IDLE_LEVEL, then return to IDLE.
REQ-020 start SHALL be ignored in SHIFT, GAP and DONE; changes to pattern, len or reps after capture SHALL NOT affect a transmission already in progress.
REQ-021 start=1 in the IDLE cycle that immediately follows DONE SHALL be accepted normally.
REQ-022 len=0 SHALL be legal: it sends the single bit pattern[0] on each pass.
REQ-023 reps=15 SHALL produce 16 passes; the repetition counter SHALL NOT wrap.
REQ-024 In IDLE, o SHALL equal IDLE_LEVEL and valid, busy and done SHALL all be 0.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, o=IDLE_LEVEL, valid=0, busy=0 and done=0 at that edge, clearing the bit index, repetition and gap counters.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst asserted mid-transmission SHALL abort it immediately, with no done pulse, and no residual bits SHALL be sent after rst is released.

Verification
REQ-028 Bench SHALL cover: WIDTH=8, pattern=8'b1011_0010, len=3, reps=0, start at cycle 0 -> o/valid = 0,0,1,0 in cycles 1-4 with valid=1; done=1 in cycle 5; busy=1 in cycles 1-5.
REQ-029 Bench SHALL cover: GAP=2, pattern=8'h05, len=2, reps=1 -> cycles 1-3 send 1,0,1; cycles 4-5 have valid=0; cycles 6-8 send 1,0,1; done in cycle 9.
REQ-030 Bench SHALL cover: GAP=0, len=0, pattern[0]=1, reps=15 -> 16 consecutive cycles with valid=1 and o=1; done in cycle 17.
REQ-031 Bench SHALL cover: start pulsed in cycle 2 while busy, and pattern changed in cycle 2 -> no restart, the originally captured bits are sent, exactly one done pulse.
REQ-032 Bench SHALL cover: rst=1 in cycle 3 of an 8-bit pass -> o=IDLE_LEVEL, valid=0, busy=0 from cycle 3 onward, no done pulse; a new start in cycle 5 sends its first bit in cycle 6.
REQ-033 Bench SHALL cover: loopback of o into the downstream sequence detector i with a pattern containing the target sequence -> detector out=1 exactly once per occurrence per pass.
